nios2_cpu_oci_dct_packer: RTL and testbench

Packs 2-bit compressed-trace codes from the Nios II OCI trace path into 30-bit frames and hands each frame to the OCI test bench monitor (`dct_buffer`, `dct_count`, `test_ending`, `test_has_ended`). Sits directly upstream of the OCI test bench. Provides a one-frame output register, backpressure to the trace source, idle and explicit flush, and the end-of-test drain sequence.

---
 rtl/nios2_cpu_oci_dct_packer.sv | 177 +++++++++++++++++
 tb/tb_nios2_cpu_oci_dct_packer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_cpu_oci_dct_packer.sv
// Packs 2-bit trace codes into 30-bit OCI test-bench frames.
// Optional OCI_DCT_DROP_EN: drop codes instead of backpressure, count drops.
module nios2_cpu_oci_dct_packer #(
  parameter int IDLE_FLUSH_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [1:0]  code,
  output logic        code_ready,
  input  logic        flush,
  input  logic        end_req,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_ending,
  output logic        test_has_ended
`ifdef OCI_DCT_DROP_EN
  ,
  output logic [7:0]  drop_count
`endif
);

  typedef enum logic [1:0] {
    RUN,
    ENDING,
    ENDED
  } state_e;

  localparam logic [7:0] IDLE_LIM = 8'(IDLE_FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [29:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] obuf_q, obuf_d;
  logic [3:0]  ocnt_q, ocnt_d;
  logic        fv_q, fv_d;
  logic        pend_q, pend_d;
  logic [7:0]  idle_q, idle_d;
  logic        live_q;

  logic full, room, run, rdy, take, xfer, idle_hit;

`ifdef OCI_DCT_DROP_EN
  logic [7:0] drop_q, drop_d;
  logic       drop;
`endif

  always_comb begin
    full = (cnt_q == 4'd15);
    room = !full && !pend_q;
    run  = (state_q == RUN) && live_q;
`ifdef OCI_DCT_DROP_EN
    rdy  = run;
    take = code_valid && run && room;
    drop = code_valid && run && !room;
`else
    rdy  = run && room;
    take = code_valid && rdy;
`endif
    xfer = (full || (pend_q && cnt_q != 4'd0))
           && (!fv_q || frame_ready);
  end

  // Accumulator and output register
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    obuf_d = obuf_q;
    ocnt_d = ocnt_q;
    fv_d   = fv_q;
    if (xfer) begin
      obuf_d = acc_q;
      ocnt_d = cnt_q;
      acc_d  = '0;
      cnt_d  = '0;
      fv_d   = 1'b1;
    end else begin
      if (take) begin
        acc_d[{cnt_q, 1'b0} +: 2] = code;
        cnt_d = cnt_q + 4'd1;
      end
      if (fv_q && frame_ready) begin
        fv_d = 1'b0;
      end
    end
  end

  always_comb begin
    idle_d = idle_q;
    if (take || xfer || cnt_q == 4'd0) begin
      idle_d = '0;
    end else if (idle_q != 8'hFF) begin
      idle_d = idle_q + 8'd1;
    end
    idle_hit = (IDLE_LIM != 8'd0) && (cnt_q != 4'd0)
               && (idle_d == IDLE_LIM);
  end

  // Set wins over clear so an empty flush lingers for one cycle
  always_comb begin
    pend_d = pend_q;
    if (xfer || cnt_q == 4'd0) begin
      pend_d = 1'b0;
    end
    if ((state_q == RUN && (flush || end_req))
        || state_q == ENDING || idle_hit) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (end_req) state_d = ENDING;
      end
      ENDING: begin
        if (cnt_q == 4'd0 && !fv_q) state_d = ENDED;
      end
      ENDED: state_d = ENDED;
      default: state_d = RUN;
    endcase
  end

`ifdef OCI_DCT_DROP_EN
  always_comb begin
    drop_d = drop_q;
    if (drop && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
      obuf_q  <= '0;
      ocnt_q  <= '0;
      fv_q    <= 1'b0;
      pend_q  <= 1'b0;
      idle_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      obuf_q  <= obuf_d;
      ocnt_q  <= ocnt_d;
      fv_q    <= fv_d;
      pend_q  <= pend_d;
      idle_q  <= idle_d;
      live_q  <= 1'b1;
    end
  end

  assign code_ready     = rdy;
  assign frame_valid    = fv_q;
  assign dct_buffer     = obuf_q;
  assign dct_count      = ocnt_q;
  assign test_ending    = (state_q == ENDING);
  assign test_has_ended = (state_q == ENDED);

endmodule

// File: tb/tb_nios2_cpu_oci_dct_packer.sv
// Bench for nios2_cpu_oci_dct_packer: frame table, scoreboard,
// backpressure, idle flush, drain and reset sequences.
module tb_nios2_cpu_oci_dct_packer;

  localparam int IDLE = 4;
`ifdef OCI_DCT_DROP_EN
  localparam int EXP_LO = 0;
`else
  localparam int EXP_LO = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        code_valid = 1'b0;
  logic [1:0]  code = 2'd0;
  logic        flush = 1'b0;
  logic        end_req = 1'b0;
  logic        frame_ready = 1'b1;
  logic        code_ready;
  logic        frame_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
`ifdef OCI_DCT_DROP_EN
  logic [7:0]  drop_count;
`endif

  nios2_cpu_oci_dct_packer #(
    .IDLE_FLUSH_CYCLES(IDLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .code_valid(code_valid),
    .code(code),
    .code_ready(code_ready),
    .flush(flush),
    .end_req(end_req),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .dct_buffer(dct_buffer),
    .dct_count(dct_count),
    .test_ending(test_ending),
    .test_has_ended(test_has_ended)
`ifdef OCI_DCT_DROP_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          first;
    int          stp;
    int          n;
    logic [29:0] exp_buf;
    logic [3:0]  exp_cnt;
  } vec_t;

  typedef struct packed {
    logic [29:0] b;
    logic [3:0]  c;
  } frm_t;

  frm_t sbq[$];
  frm_t f;
  int   nvec = 0;
  int   nerr = 0;
  int   n_hs = 0;
  int   lo_cnt = 0;
  bit   lo_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  always @(negedge clk) begin
    if (!reset && frame_valid && frame_ready) begin
      n_hs++;
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_frame: got %0h/%0d want none",
                 dct_buffer, dct_count);
      end else begin
        f = sbq.pop_front();
        check("frame_buf", 32'(dct_buffer), 32'(f.b));
        check("frame_cnt", 32'(dct_count), 32'(f.c));
      end
    end
    if (lo_en && !code_ready) lo_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [1:0] c);
    bit ok = 1'b0;
    bit r;
    code_valid = 1'b1;
    code = c;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      r = code_ready;
      step();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    code_valid = 1'b0;
    if (!ok) timeout("send_code");
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (sbq.size() == 0 && !frame_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) timeout("drain");
  endtask

  task automatic push(input logic [29:0] b, input logic [3:0] c);
    frm_t e;
    e.b = b;
    e.c = c;
    sbq.push_back(e);
  endtask

  vec_t tv[7];

  initial begin
    int hs0;
    int k;
    bit seen;

    tv[0] = '{1, 0, 15, 30'h15555555, 4'd15};
    tv[1] = '{3, 3, 3, 30'h0000001B, 4'd3};
    tv[2] = '{2, 0, 1, 30'h00000002, 4'd1};
    tv[3] = '{3, 0, 8, 30'h0000FFFF, 4'd8};
    tv[4] = '{2, 3, 15, 30'h06C6C6C6, 4'd15};
    tv[5] = '{0, 1, 5, 30'h000000E4, 4'd5};
    tv[6] = '{2, 0, 14, 30'h0AAAAAAA, 4'd14};

    #12;
    check("rst_ready", 32'(code_ready), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_buf", 32'(dct_buffer), 32'd0);
    check("rst_cnt", 32'(dct_count), 32'd0);
    check("rst_ending", 32'(test_ending), 32'd0);
    check("rst_ended", 32'(test_has_ended), 32'd0);
`ifdef OCI_DCT_DROP_EN
    check("rst_drop", 32'(drop_count), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    step();
    check("ready_after_rst", 32'(code_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      push(tv[i].exp_buf, tv[i].exp_cnt);
      lo_cnt = 0;
      lo_en = 1'b1;
      for (int j = 0; j < tv[i].n; j++) begin
        send_code(2'(tv[i].first + j * tv[i].stp));
      end
      if (tv[i].n < 15) do_flush();
      repeat (4) step();
      lo_en = 1'b0;
      if (tv[i].n == 15) check("ready_lo_cycles", 32'(lo_cnt), 32'(EXP_LO));
      wait_drain();
    end

    hs0 = n_hs;
    do_flush();
    repeat (6) step();
    check("empty_flush", 32'(n_hs), 32'(hs0));

`ifndef OCI_DCT_DROP_EN
    frame_ready = 1'b0;
    push(30'h15555555, 4'd15);
    push(30'h3FFFFFFF, 4'd15);
    for (int j = 0; j < 15; j++) send_code(2'd1);
    for (int j = 0; j < 15; j++) send_code(2'd3);
    repeat (3) step();
    check("bp_ready", 32'(code_ready), 32'd0);
    check("bp_fv", 32'(frame_valid), 32'd1);
    check("bp_buf", 32'(dct_buffer), 32'h15555555);
    repeat (5) step();
    check("bp_buf_hold", 32'(dct_buffer), 32'h15555555);
    check("bp_cnt_hold", 32'(dct_count), 32'd15);
    frame_ready = 1'b1;
    wait_drain();
`else
    frame_ready = 1'b0;
    push(30'h15555555, 4'd15);
    push(30'h15555555, 4'd15);
    for (int j = 0; j < 40; j++) send_code(2'd1);
    repeat (2) step();
    check("drop_count", 32'(drop_count), 32'd10);
    frame_ready = 1'b1;
    wait_drain();
    check("drop_count_after", 32'(drop_count), 32'd10);
`endif

    push(30'h2, 4'd1);
    send_code(2'd2);
    k = 0;
    seen = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (frame_valid) begin
        k = t;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("idle_flush");
    else check("idle_latency", 32'(k), 32'd6);
    step();
    wait_drain();

    push(30'h139, 4'd5);
    send_code(2'd1);
    send_code(2'd2);
    send_code(2'd3);
    send_code(2'd0);
    send_code(2'd1);
    end_req = 1'b1;
    step();
    end_req = 1'b0;
    check("ending_hi", 32'(test_ending), 32'd1);
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (test_has_ended) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("test_has_ended");
    check("ending_lo", 32'(test_ending), 32'd0);
    check("ended_hi", 32'(test_has_ended), 32'd1);
    check("end_frames_left", 32'(sbq.size()), 32'd0);
    step();
    hs0 = n_hs;
    code_valid = 1'b1;
    code = 2'd3;
    flush = 1'b1;
    repeat (5) step();
    check("ended_ready", 32'(code_ready), 32'd0);
    code_valid = 1'b0;
    flush = 1'b0;
    repeat (3) step();
    check("ended_no_frame", 32'(n_hs), 32'(hs0));
    check("ended_sticky", 32'(test_has_ended), 32'd1);

    reset = 1'b1;
    #1;
    check("async_rst_ended", 32'(test_has_ended), 32'd0);
    check("async_rst_ready", 32'(code_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    send_code(2'd3);
    send_code(2'd2);
    reset = 1'b1;
    #1;
    check("mid_rst_fv", 32'(frame_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    hs0 = n_hs;
    do_flush();
    repeat (6) step();
    check("mid_rst_discard", 32'(n_hs), 32'(hs0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
